fpu_op_sequencer: RTL and testbench
===================================

FPU_OP_SEQUENCER -- requirements
Module: fpu_op_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning command FIFO entries (power of 2, 2..16).
REQ-002 SHALL have parameter TIMEOUT, default 64, meaning max WAIT cycles before abort (2..255).
REQ-003 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_l  in  1  asynchronous active-low reset.
REQ-005 SHALL have ports cmd_valid in 1 / cmd_ready out 1, the command handshake.
REQ-006 SHALL have ports cmd_op in 13 (one-hot op_valids code), cmd_opa/cmd_opb/cmd_opc in 32 each, cmd_frm in 3.
REQ-007 SHALL have ports fpu_opa/fpu_opb/fpu_opc out 32 each, fpu_frm out 3, fpu_op_valids out 13, driving the FPU.
REQ-008 SHALL have ports fpu_result in 32, fpu_valids in 13, fpu_exceptions in 5, the FPU return path.
REQ-009 SHALL have ports rsp_valid out 1 / rsp_ready in 1, rsp_result out 32, rsp_flags out 5, rsp_timeout out 1, rsp_err out 1.
REQ-010 SHALL have ports busy out 1, done_irq out 1, irq_clr in 1, fflags_acc out 5, flags_clr in 1.

Function
REQ-011 SHALL define FPU completion as |fpu_valids[12:2]; fpu_valids[1:0] SHALL be ignored.
REQ-012 SHALL queue commands in a DEPTH-entry FIFO; push when cmd_valid && cmd_ready; cmd_ready = !full.
REQ-013 SHALL allow simultaneous push and pop (occupancy unchanged); pointers SHALL wrap modulo DEPTH; no bypass of an empty FIFO.
REQ-014 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP.
REQ-015 IDLE: if FIFO non-empty, pop head into operand/op/frm holding registers, go to ISSUE; else stay.
REQ-016 ISSUE: drive fpu_op_valids = held op for exactly one cycle (zero in all other states); go to WAIT with timeout counter = 0.
REQ-017 ISSUE with held op[12:2]==0: no FPU pulse; go directly to RESP with rsp_err=1, rsp_result=0, rsp_flags=0.
REQ-018 WAIT: on completion capture fpu_result and fpu_exceptions, go to RESP with rsp_timeout=0.
REQ-019 WAIT: counter increments each cycle; at counter == TIMEOUT-1 with no completion, go to RESP with rsp_timeout=1, rsp_result=0, rsp_flags=0; completion in that same cycle SHALL win (normal response).
REQ-020 Completion seen outside WAIT SHALL be ignored.
REQ-021 RESP: rsp_valid=1 with stable rsp_* until rsp_ready; on handshake go to IDLE (next pop no earlier than the following cycle).
REQ-022 fpu_opa/b/c and fpu_frm SHALL equal the holding registers, stable from ISSUE until the next pop.
REQ-023 Minimum latency: command accepted at edge N, fpu_op_valids asserted during cycle N+2.
REQ-024 busy SHALL be 1 when state != IDLE or FIFO non-empty.
REQ-025 done_irq SHALL set on entry to RESP, clear on irq_clr; set SHALL win over simultaneous clear.
REQ-026 fflags_acc SHALL OR in captured fpu_exceptions on each normal completion, clear on flags_clr; accrual SHALL win over simultaneous clear.

Reset
REQ-027 rst_l low SHALL immediately force: state IDLE, FIFO empty, counter 0, holding registers 0, fpu_op_valids 0, rsp_valid 0, rsp_* 0, done_irq 0, fflags_acc 0, busy 0; cmd_ready SHALL be 1 after reset release.
REQ-028 Reset mid-operation SHALL discard queued and in-flight commands; FPU completion arriving after reset release SHALL be ignored (state IDLE).

Verification
REQ-029 Single op: push cmd_op=13'h0004, opa=3F800000, opb=40000000; FPU returns valids=0004, result=40400000, exc=0 three cycles after pulse -> one-cycle fpu_op_valids=0004 at N+2, rsp_result=40400000, rsp_timeout=0, done_irq=1.
REQ-030 FIFO full: push DEPTH+1 commands with FPU stalled -> cmd_ready=0 after DEPTH accepts; all DEPTH responses return in push order after FPU resumes.
REQ-031 Timeout: FPU never completes, TIMEOUT=64 -> rsp_valid exactly 64 cycles after the WAIT entry cycle's counter start, rsp_timeout=1, rsp_result=0, fflags_acc unchanged.
REQ-032 Backpressure and illegal op: hold rsp_ready=0 for 10 cycles -> rsp_* stable, no new fpu_op_valids pulse; push cmd_op=13'h0003 -> rsp_err=1, no FPU pulse.
REQ-033 Flags/irq collision: exc=5'b00001 completes same cycle as flags_clr=1, irq_clr=1 on entry to RESP -> fflags_acc=00001, done_irq=1.
REQ-034 Reset mid-WAIT: assert rst_l=0 during WAIT with 2 queued commands, then FPU completes -> all outputs at reset values, no rsp_valid.

Source files
------------

// File: rtl/fpu_op_sequencer.sv
// fpu_op_sequencer: queues FPU commands, issues them one at a time, waits for
// completion or timeout, and holds the response until it is accepted.
module fpu_op_sequencer #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_l,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [12:0] cmd_op,
    input  logic [31:0] cmd_opa,
    input  logic [31:0] cmd_opb,
    input  logic [31:0] cmd_opc,
    input  logic [2:0]  cmd_frm,
    output logic [31:0] fpu_opa,
    output logic [31:0] fpu_opb,
    output logic [31:0] fpu_opc,
    output logic [2:0]  fpu_frm,
    output logic [12:0] fpu_op_valids,
    input  logic [31:0] fpu_result,
    input  logic [12:0] fpu_valids,
    input  logic [4:0]  fpu_exceptions,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic [4:0]  rsp_flags,
    output logic        rsp_timeout,
    output logic        rsp_err,
    output logic        busy,
    output logic        done_irq,
    input  logic        irq_clr,
    output logic [4:0]  fflags_acc,
    input  logic        flags_clr
);

    localparam int unsigned AW        = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);
    localparam logic [7:0]  TO_LAST   = 8'(TIMEOUT - 1);

    typedef struct packed {
        logic [12:0] op;
        logic [31:0] opa;
        logic [31:0] opb;
        logic [31:0] opc;
        logic [2:0]  frm;
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t        state;
    state_t        next_state;

    cmd_t          fifo_mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    logic [12:0]   hold_op;
    logic [7:0]    to_cnt;

    logic          fpu_done;
    logic          op_legal;
    logic          wait_done;
    logic          wait_expire;
    logic          issue_illegal;
    logic          enter_resp;

    // Low two valid bits are not completion indicators and are deliberately dropped.
    logic          unused_low_valids;
    assign unused_low_valids = ^fpu_valids[1:0];

    assign full      = (count == DEPTH_CNT);
    assign empty     = (count == '0);
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;
    assign pop       = (state == IDLE) && !empty;

    assign fpu_done      = |fpu_valids[12:2];
    assign op_legal      = |hold_op[12:2];
    assign wait_done     = (state == WAIT) && fpu_done;
    assign wait_expire   = (state == WAIT) && !fpu_done && (to_cnt == TO_LAST);
    assign issue_illegal = (state == ISSUE) && !op_legal;
    assign enter_resp    = wait_done || wait_expire || issue_illegal;

    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE) || !empty;

    // Command storage; contents need no reset because occupancy is tracked by count.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= '{op: cmd_op, opa: cmd_opa, opb: cmd_opb,
                                  opc: cmd_opc, frm: cmd_frm};
        end
    end

    // FIFO pointers and occupancy; push and pop in one cycle leave count unchanged.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) state <= IDLE;
        else        state <= next_state;
    end

    // Next-state logic and the one-cycle FPU issue pulse.
    always_comb begin
        next_state    = state;
        fpu_op_valids = '0;
        case (state)
            IDLE:  if (!empty) next_state = ISSUE;
            ISSUE: begin
                if (op_legal) begin
                    fpu_op_valids = hold_op;
                    next_state    = WAIT;
                end else begin
                    next_state = RESP;
                end
            end
            WAIT:  if (fpu_done || (to_cnt == TO_LAST)) next_state = RESP;
            RESP:  if (rsp_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Holding registers load on pop and stay stable until the next pop.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            hold_op <= '0;
            fpu_opa <= '0;
            fpu_opb <= '0;
            fpu_opc <= '0;
            fpu_frm <= '0;
        end else if (pop) begin
            hold_op <= fifo_mem[rd_ptr].op;
            fpu_opa <= fifo_mem[rd_ptr].opa;
            fpu_opb <= fifo_mem[rd_ptr].opb;
            fpu_opc <= fifo_mem[rd_ptr].opc;
            fpu_frm <= fifo_mem[rd_ptr].frm;
        end
    end

    // WAIT cycle counter: zeroed in ISSUE, counts every WAIT cycle.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l)               to_cnt <= '0;
        else if (state == ISSUE)  to_cnt <= '0;
        else if (state == WAIT)   to_cnt <= to_cnt + 1'b1;
    end

    // Response registers are captured on the transition into RESP only.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            rsp_result  <= '0;
            rsp_flags   <= '0;
            rsp_timeout <= 1'b0;
            rsp_err     <= 1'b0;
        end else if (wait_done) begin
            rsp_result  <= fpu_result;
            rsp_flags   <= fpu_exceptions;
            rsp_timeout <= 1'b0;
            rsp_err     <= 1'b0;
        end else if (wait_expire) begin
            rsp_result  <= '0;
            rsp_flags   <= '0;
            rsp_timeout <= 1'b1;
            rsp_err     <= 1'b0;
        end else if (issue_illegal) begin
            rsp_result  <= '0;
            rsp_flags   <= '0;
            rsp_timeout <= 1'b0;
            rsp_err     <= 1'b1;
        end
    end

    // Completion interrupt: set on RESP entry has priority over clear.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l)          done_irq <= 1'b0;
        else if (enter_resp) done_irq <= 1'b1;
        else if (irq_clr)    done_irq <= 1'b0;
    end

    // Sticky exception flags: accrual on normal completion has priority over clear.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l)         fflags_acc <= '0;
        else if (wait_done) fflags_acc <= fflags_acc | fpu_exceptions;
        else if (flags_clr) fflags_acc <= '0;
    end

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// tb_fpu_op_sequencer: directed stimulus with a response scoreboard, an FPU
// behavioural model that checks each issue, and a decoupled response monitor.
module tb_fpu_op_sequencer;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 64;

    logic        clk;
    logic        rst_l;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [12:0] cmd_op;
    logic [31:0] cmd_opa, cmd_opb, cmd_opc;
    logic [2:0]  cmd_frm;
    logic [31:0] fpu_opa, fpu_opb, fpu_opc;
    logic [2:0]  fpu_frm;
    logic [12:0] fpu_op_valids;
    logic [31:0] fpu_result;
    logic [12:0] fpu_valids;
    logic [4:0]  fpu_exceptions;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_result;
    logic [4:0]  rsp_flags;
    logic        rsp_timeout, rsp_err;
    logic        busy, done_irq, irq_clr, flags_clr;
    logic [4:0]  fflags_acc;

    fpu_op_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_l(rst_l),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_opa(cmd_opa), .cmd_opb(cmd_opb), .cmd_opc(cmd_opc), .cmd_frm(cmd_frm),
        .fpu_opa(fpu_opa), .fpu_opb(fpu_opb), .fpu_opc(fpu_opc), .fpu_frm(fpu_frm),
        .fpu_op_valids(fpu_op_valids), .fpu_result(fpu_result),
        .fpu_valids(fpu_valids), .fpu_exceptions(fpu_exceptions),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_flags(rsp_flags), .rsp_timeout(rsp_timeout), .rsp_err(rsp_err),
        .busy(busy), .done_irq(done_irq), .irq_clr(irq_clr),
        .fflags_acc(fflags_acc), .flags_clr(flags_clr)
    );

    typedef struct {
        logic [31:0] res;
        logic [4:0]  flags;
        logic        to;
        logic        err;
    } rsp_t;

    typedef struct {
        logic [12:0] op;
        logic [31:0] a, b, c;
        logic [2:0]  frm;
        int          lat_ref;
    } iss_t;

    typedef struct {
        int          dly;
        logic [12:0] v;
        logic [31:0] res;
        logic [4:0]  exc;
        bit          collide;
    } plan_t;

    rsp_t  rsp_q[$];
    iss_t  iss_q[$];
    plan_t plan_q[$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int pulse_cyc = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drives one command (caller sits just after a rising edge) and records expectations.
    task automatic push(input logic [12:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] c, input logic [2:0] frm, input int dly,
                        input logic [12:0] v, input logic [31:0] res, input logic [4:0] exc,
                        input bit collide, input bit chk_lat);
        int   n;
        bit   acc;
        rsp_t r;
        n = 0;
        acc = 0;
        cmd_valid = 1'b1; cmd_op = op; cmd_opa = a; cmd_opb = b; cmd_opc = c; cmd_frm = frm;
        while (!acc && n <= 300) begin
            @(negedge clk);
            if (cmd_ready) acc = 1;
            @(posedge clk); #1;
            n++;
        end
        cmd_valid = 1'b0;
        if (!acc) begin
            chk("cmd_accept_bound", 0, 1);
            return;
        end
        if (!(|op[12:2])) begin
            r = '{res: 32'h0, flags: 5'h0, to: 1'b0, err: 1'b1};
        end else begin
            if (dly >= 2 && dly <= TIMEOUT && (|v[12:2]))
                r = '{res: res, flags: exc, to: 1'b0, err: 1'b0};
            else
                r = '{res: 32'h0, flags: 5'h0, to: 1'b1, err: 1'b0};
            iss_q.push_back('{op: op, a: a, b: b, c: c, frm: frm, lat_ref: chk_lat ? cyc : -1});
            plan_q.push_back('{dly: dly, v: v, res: res, exc: exc, collide: collide});
        end
        rsp_q.push_back(r);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while ((busy || rsp_q.size() != 0) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_idle", {busy, rsp_q.size() == 0}, {1'b0, 1'b1});
        @(posedge clk); #1;
    endtask

    task automatic wait_rsp_valid();
        int n;
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("rsp_valid_seen", rsp_valid, 1);
    endtask

    // FPU model: checks every issue pulse, then replays the planned completion.
    initial begin
        iss_t  e;
        plan_t p;
        forever begin
            @(negedge clk);
            if (rst_l && fpu_op_valids != '0) begin
                pulse_cyc = cyc;
                if (iss_q.size() == 0) begin
                    chk("unexpected_issue", fpu_op_valids, 0);
                end else begin
                    e = iss_q.pop_front();
                    chk("issue_op", fpu_op_valids, e.op);
                    chk("issue_operands", {fpu_opa, fpu_opb, fpu_opc, fpu_frm},
                        {e.a, e.b, e.c, e.frm});
                    if (e.lat_ref >= 0) chk("issue_latency", cyc - e.lat_ref, 1);
                end
                if (plan_q.size() != 0) begin
                    p = plan_q.pop_front();
                    @(negedge clk);
                    chk("issue_pulse_width", fpu_op_valids, 0);
                    if (p.dly >= 2) begin
                        repeat (p.dly - 1) @(posedge clk);
                        #1;
                        fpu_valids = p.v; fpu_result = p.res; fpu_exceptions = p.exc;
                        if (p.collide) begin
                            flags_clr = 1'b1; irq_clr = 1'b1;
                        end
                        @(posedge clk); #1;
                        fpu_valids = '0; fpu_result = '0; fpu_exceptions = '0;
                        if (p.collide) begin
                            flags_clr = 1'b0; irq_clr = 1'b0;
                        end
                    end
                end
            end
        end
    end

    // Response monitor: every accepted response is compared against the scoreboard.
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            if (rst_l && rsp_valid && rsp_ready) begin
                if (rsp_q.size() == 0) begin
                    chk("unexpected_rsp", 1, 0);
                end else begin
                    e = rsp_q.pop_front();
                    chk("rsp_result", rsp_result, e.res);
                    chk("rsp_flags", rsp_flags, e.flags);
                    chk("rsp_timeout", rsp_timeout, e.to);
                    chk("rsp_err", rsp_err, e.err);
                    if (e.to) chk("timeout_latency", cyc - pulse_cyc, TIMEOUT + 1);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_l = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_opa = '0; cmd_opb = '0;
        cmd_opc = '0; cmd_frm = '0; rsp_ready = 1'b0; irq_clr = 1'b0; flags_clr = 1'b0;
        fpu_valids = '0; fpu_result = '0; fpu_exceptions = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_op_valids", fpu_op_valids, 0);
        chk("rst_irq_flags", {done_irq, fflags_acc}, 0);
        rst_l = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_cmd_ready", cmd_ready, 1);

        // Single op: 1.0 + 2.0, completion three cycles after the pulse.
        rsp_ready = 1'b1;
        push(13'h0004, 32'h3F800000, 32'h40000000, 32'h0, 3'b000,
             3, 13'h0004, 32'h40400000, 5'b00000, 0, 1);
        wait_idle();
        chk("single_done_irq", done_irq, 1);
        chk("single_fflags", fflags_acc, 5'b00000);
        irq_clr = 1'b1; @(posedge clk); #1; irq_clr = 1'b0;
        chk("irq_cleared", done_irq, 0);

        // Flag accrual across two ops; low valid bit set alongside a real completion.
        push(13'h0010, 32'hC0400000, 32'h3F800000, 32'h40000000, 3'b011,
             2, 13'h0010, 32'hC0000000, 5'b00100, 0, 1);
        push(13'h1000, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h0, 3'b001,
             5, 13'h1001, 32'h7F800000, 5'b10000, 0, 0);
        wait_idle();
        chk("accrued_flags", fflags_acc, 5'b10100);

        // Illegal ops: only low bits, and all-zero.
        push(13'h0003, 32'h1, 32'h2, 32'h3, 3'b000, 2, 13'h0, 32'h0, 5'b0, 0, 0);
        push(13'h0000, 32'h4, 32'h5, 32'h6, 3'b000, 2, 13'h0, 32'h0, 5'b0, 0, 0);
        wait_idle();
        chk("illegal_keeps_flags", fflags_acc, 5'b10100);
        chk("illegal_sets_irq", done_irq, 1);

        // Timeout: only low valid bits returned; then completion on the last WAIT cycle;
        // then completion one cycle too late (lands in RESP and is ignored).
        push(13'h0008, 32'h11, 32'h22, 32'h33, 3'b010, 2, 13'h0003, 32'hFFFFFFFF, 5'b11111, 0, 0);
        wait_idle();
        chk("timeout_keeps_flags", fflags_acc, 5'b10100);
        push(13'h0008, 32'h44, 32'h55, 32'h66, 3'b000, TIMEOUT, 13'h0008, 32'h3E000000, 5'b00000, 0, 1);
        push(13'h0008, 32'h77, 32'h88, 32'h99, 3'b000, TIMEOUT + 1, 13'h0008, 32'h11111111, 5'b01000, 0, 0);
        wait_idle();
        chk("late_completion_ignored", fflags_acc, 5'b10100);
        flags_clr = 1'b1; @(posedge clk); #1; flags_clr = 1'b0;
        chk("flags_cleared", fflags_acc, 5'b00000);

        // Backpressure: response must hold and no new issue may start.
        rsp_ready = 1'b0;
        push(13'h0020, 32'hAAAA0000, 32'hBBBB0000, 32'h0, 3'b100, 2, 13'h0020, 32'h12345678, 5'b00010, 0, 1);
        push(13'h0040, 32'hCCCC0000, 32'hDDDD0000, 32'h0, 3'b000, 2, 13'h0040, 32'h87654321, 5'b00000, 0, 0);
        wait_rsp_valid();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_rsp", {rsp_valid, rsp_result, rsp_flags, rsp_timeout, rsp_err},
                {1'b1, 32'h12345678, 5'b00010, 1'b0, 1'b0});
            chk("bp_no_issue", fpu_op_valids, 0);
            chk("bp_busy", busy, 1);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        wait_idle();

        // FIFO full: sequencer parked in RESP, DEPTH more commands fill the queue.
        rsp_ready = 1'b0;
        push(13'h0080, 32'h1000, 32'h2000, 32'h0, 3'b000, 2, 13'h0080, 32'h0BADF00D, 5'b0, 0, 0);
        wait_rsp_valid();
        @(posedge clk); #1;
        for (int i = 0; i < DEPTH; i++) begin
            push(13'h0004 << i, 32'h100 + i, 32'h200 + i, 32'h300 + i, 3'(i),
                 2, 13'h0004 << i, 32'hA0000000 + i, 5'b0, 0, 0);
        end
        @(negedge clk);
        chk("full_cmd_ready", cmd_ready, 0);
        @(posedge clk); #1;
        fork
            begin
                repeat (6) @(posedge clk);
                #1;
                rsp_ready = 1'b1;
            end
        join_none
        push(13'h0800, 32'h900, 32'hA00, 32'hB00, 3'b111, 3, 13'h0800, 32'hA0000009, 5'b0, 0, 0);
        wait_idle();

        // Set-vs-clear collision: completion coincides with flags_clr and irq_clr.
        flags_clr = 1'b1; irq_clr = 1'b1; @(posedge clk); #1; flags_clr = 1'b0; irq_clr = 1'b0;
        chk("pre_collide_clear", {done_irq, fflags_acc}, 0);
        push(13'h0004, 32'h40000000, 32'h40000000, 32'h0, 3'b000, 3, 13'h0004, 32'h40800000, 5'b00001, 1, 1);
        wait_idle();
        chk("collide_fflags", fflags_acc, 5'b00001);
        chk("collide_irq", done_irq, 1);

        // Reset during WAIT with two queued commands, then a stray completion.
        push(13'h0004, 32'h5, 32'h6, 32'h0, 3'b000, -1, 13'h0, 32'h0, 5'b0, 0, 1);
        push(13'h0008, 32'h7, 32'h8, 32'h0, 3'b000, 2, 13'h0008, 32'h1, 5'b0, 0, 0);
        push(13'h0010, 32'h9, 32'hA, 32'h0, 3'b000, 2, 13'h0010, 32'h2, 5'b0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("midwait_busy", busy, 1);
        #2;
        rst_l = 1'b0;
        #1;
        chk("arst_outputs", {busy, rsp_valid, fpu_op_valids, done_irq, fflags_acc,
                             rsp_result, rsp_flags, rsp_timeout, rsp_err, cmd_ready},
            {1'b0, 1'b0, 13'h0, 1'b0, 5'h0, 32'h0, 5'h0, 1'b0, 1'b0, 1'b1});
        chk("arst_hold_regs", {fpu_opa, fpu_opb, fpu_opc, fpu_frm}, 0);
        rsp_q.delete(); iss_q.delete(); plan_q.delete();
        @(posedge clk); @(posedge clk); #1;
        rst_l = 1'b1;
        fpu_valids = 13'h0004; fpu_result = 32'hDEADBEEF; fpu_exceptions = 5'b11111;
        @(posedge clk); #1;
        fpu_valids = '0; fpu_result = '0; fpu_exceptions = '0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("post_rst_no_rsp", {rsp_valid, fpu_op_valids}, 0);
        end
        chk("post_rst_state", {busy, done_irq, fflags_acc, cmd_ready, rsp_result},
            {1'b0, 1'b0, 5'h0, 1'b1, 32'h0});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
